// File: rtl/gpio_in_sync_irq.sv
// GPIO input path: two-flop synchronizer, optional per-pin debounce,
// edge detection and sticky per-pin interrupt status with a masked IRQ.
module gpio_in_sync_irq #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEB_DIV    = 8
) (
  input  logic                  pclk,
  input  logic                  p_reset,
  input  logic [DATA_WIDTH-1:0] gpio_pin_in,
  input  logic [DATA_WIDTH-1:0] n_gpio_pin_oe,
  input  logic [DATA_WIDTH-1:0] deb_en,
  input  logic [DATA_WIDTH-1:0] irq_rise,
  input  logic [DATA_WIDTH-1:0] irq_fall,
  input  logic [DATA_WIDTH-1:0] irq_en,
  input  logic [DATA_WIDTH-1:0] irq_clr,
  output logic [DATA_WIDTH-1:0] gpio_in_val,
  output logic [DATA_WIDTH-1:0] irq_status,
  output logic                  gpio_irq
);

  localparam int unsigned    CNT_W   = (DEB_DIV > 2) ? $clog2(DEB_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_DIV - 1);

  logic [DATA_WIDTH-1:0] sync1_q, sync2_q;
  logic [DATA_WIDTH-1:0] samp_q, samp_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic [DATA_WIDTH-1:0] rise, fall, set_evt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tick;

  // Debounce sample-period counter, wraps at DEB_DIV-1
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Per-pin debounce filter and edge/status next-state logic
  always_comb begin
    samp_d = tick ? sync2_q : samp_q;
    val_d  = val_q;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (!deb_en[i]) begin
        val_d[i] = sync2_q[i];
      end else if (tick && (sync2_q[i] == samp_q[i])) begin
        val_d[i] = sync2_q[i];
      end
    end
    rise     = val_q & ~prev_q;
    fall     = ~val_q & prev_q;
    set_evt  = ((rise & irq_rise) | (fall & irq_fall)) & n_gpio_pin_oe;
    // Set has priority over a simultaneous clear
    status_d = (status_q & ~irq_clr) | set_evt;
  end

  // State registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      samp_q   <= '0;
      val_q    <= '0;
      prev_q   <= '0;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= gpio_pin_in;
      sync2_q  <= sync1_q;
      samp_q   <= samp_d;
      val_q    <= val_d;
      prev_q   <= val_q;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gpio_in_val = val_q;
  assign irq_status  = status_q;
  assign gpio_irq    = |(status_q & irq_en);

endmodule

// File: tb/tb_gpio_in_sync_irq.sv
// Directed self-checking bench for gpio_in_sync_irq (DATA_WIDTH=16, DEB_DIV=8).
module tb_gpio_in_sync_irq;

  logic        pclk;
  logic        p_reset;
  logic [15:0] gpio_pin_in, n_gpio_pin_oe, deb_en, irq_rise, irq_fall, irq_en, irq_clr;
  logic [15:0] gpio_in_val, irq_status;
  logic        gpio_irq;

  int errors = 0;
  int checks = 0;

  gpio_in_sync_irq #(.DATA_WIDTH(16), .DEB_DIV(8)) dut (
    .pclk(pclk), .p_reset(p_reset), .gpio_pin_in(gpio_pin_in),
    .n_gpio_pin_oe(n_gpio_pin_oe), .deb_en(deb_en), .irq_rise(irq_rise),
    .irq_fall(irq_fall), .irq_en(irq_en), .irq_clr(irq_clr),
    .gpio_in_val(gpio_in_val), .irq_status(irq_status), .gpio_irq(gpio_irq)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    irq_clr = '1;
    step(1);
    irq_clr = '0;
  endtask

  initial begin
    logic seen_high;
    logic found;

    p_reset = 1'b1; gpio_pin_in = '0; n_gpio_pin_oe = '1; deb_en = '0;
    irq_rise = '0; irq_fall = '0; irq_en = '0; irq_clr = '0;
    step(2);
    check("reset_val", 32'(gpio_in_val), 32'h0);
    check("reset_status", 32'(irq_status), 32'h0);
    check("reset_irq", 32'(gpio_irq), 32'h0);
    p_reset = 1'b0;
    step(2);

    // Undebounced rising edge on pin 3: value at edge 3, status/irq at edge 4
    irq_rise = 16'h0008; irq_en = 16'h0008;
    gpio_pin_in[3] = 1'b1;
    step(1); check("p3_edge1_val", 32'(gpio_in_val[3]), 32'h0);
    step(1); check("p3_edge2_val", 32'(gpio_in_val[3]), 32'h0);
    step(1); check("p3_edge3_val", 32'(gpio_in_val[3]), 32'h1);
             check("p3_edge3_status", 32'(irq_status[3]), 32'h0);
    step(1); check("p3_edge4_status", 32'(irq_status), 32'h0008);
             check("p3_edge4_irq", 32'(gpio_irq), 32'h1);
    irq_clr = 16'h0008; step(1); irq_clr = '0;
    check("p3_clr", 32'(irq_status), 32'h0);
    gpio_pin_in[3] = 1'b0;
    step(5);
    check("p3_fall_not_enabled", 32'(irq_status), 32'h0);
    irq_en = '0; irq_rise = '0;

    // Pin 2 driven as output: value follows, no status
    n_gpio_pin_oe = 16'hFFFB; irq_rise = 16'h0004; irq_fall = 16'h0004;
    gpio_pin_in[2] = 1'b1;
    step(3); check("p2_val_hi", 32'(gpio_in_val[2]), 32'h1);
    step(2); check("p2_status_hi", 32'(irq_status), 32'h0);
    gpio_pin_in[2] = 1'b0;
    step(3); check("p2_val_lo", 32'(gpio_in_val[2]), 32'h0);
    step(2); check("p2_status_lo", 32'(irq_status), 32'h0);
    n_gpio_pin_oe = '1; irq_rise = '0; irq_fall = '0;

    // Pin 7 falling with irq masked, then unmask
    irq_fall = 16'h0080;
    gpio_pin_in[7] = 1'b1;
    step(5); check("p7_rise_ignored", 32'(irq_status), 32'h0);
    gpio_pin_in[7] = 1'b0;
    step(3); check("p7_val_lo", 32'(gpio_in_val[7]), 32'h0);
    step(1); check("p7_status", 32'(irq_status), 32'h0080);
             check("p7_irq_masked", 32'(gpio_irq), 32'h0);
    irq_en = 16'h0080; #1;
    check("p7_irq_unmasked", 32'(gpio_irq), 32'h1);
    clear_all();
    irq_en = '0; irq_fall = '0;

    // Pin 5: clear coinciding with a new falling event leaves status set
    irq_rise = 16'h0020; irq_fall = 16'h0020;
    gpio_pin_in[5] = 1'b1;
    step(4); check("p5_rise_status", 32'(irq_status), 32'h0020);
    gpio_pin_in[5] = 1'b0;
    step(3); check("p5_val_lo", 32'(gpio_in_val[5]), 32'h0);
    irq_clr = 16'h0020; step(1); irq_clr = '0;
    check("p5_set_wins", 32'(irq_status), 32'h0020);
    irq_clr = 16'h0020; step(1); irq_clr = '0;
    check("p5_clr_alone", 32'(irq_status), 32'h0);
    irq_rise = '0; irq_fall = '0;

    // Pin 0 debounced: 5-cycle glitch rejected, stable high accepted
    deb_en = 16'h0001; irq_rise = 16'h0001;
    step(20);
    seen_high = 1'b0;
    gpio_pin_in[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (gpio_in_val[0]) seen_high = 1'b1;
    end
    gpio_pin_in[0] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (gpio_in_val[0]) seen_high = 1'b1;
    end
    check("p0_glitch_val", 32'(seen_high), 32'h0);
    check("p0_glitch_status", 32'(irq_status), 32'h0);
    found = 1'b0;
    gpio_pin_in[0] = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (!found) begin
        step(1);
        if (gpio_in_val[0]) found = 1'b1;
      end
    end
    check("p0_stable_within_19", 32'(found), 32'h1);
    step(1); check("p0_rise_status", 32'(irq_status), 32'h0001);
    clear_all();

    // Disabling debounce makes the pin follow sync2 on the next edge
    gpio_pin_in[0] = 1'b0;
    irq_fall = 16'h0001;
    step(3); check("p0_deb_holding", 32'(gpio_in_val[0]), 32'h1);
    deb_en = '0;
    step(1); check("p0_deb_off_val", 32'(gpio_in_val[0]), 32'h0);
    step(1); check("p0_deb_off_event", 32'(irq_status), 32'h0001);
    clear_all();
    irq_fall = '0;

    // Reset with all status set and debounce in progress
    irq_rise = '1; irq_en = '1;
    gpio_pin_in = '1;
    step(4); check("all_status_set", 32'(irq_status), 32'h0000FFFF);
             check("all_irq", 32'(gpio_irq), 32'h1);
    deb_en = '1; irq_fall = '1;
    gpio_pin_in = '0;
    step(3);
    p_reset = 1'b1; step(1); p_reset = 1'b0;
    check("rst_mid_val", 32'(gpio_in_val), 32'h0);
    check("rst_mid_status", 32'(irq_status), 32'h0);
    check("rst_mid_irq", 32'(gpio_irq), 32'h0);
    step(30);
    check("post_rst_val", 32'(gpio_in_val), 32'h0);
    check("post_rst_no_event", 32'(irq_status), 32'h0);

    // Pins held high through reset produce a rising event afterwards
    deb_en = '0; irq_fall = '0;
    gpio_pin_in = '1;
    p_reset = 1'b1; step(2); p_reset = 1'b0;
    check("hold_rst_val", 32'(gpio_in_val), 32'h0);
    step(3); check("hold_val_up", 32'(gpio_in_val), 32'h0000FFFF);
             check("hold_status_pre", 32'(irq_status), 32'h0);
    step(1); check("hold_rise_event", 32'(irq_status), 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
